// File: rtl/axi_cmd_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_dispatcher_if
// Description : Command, response, memory and core-control bundle between the
//               AXI register front end, the command dispatcher, the shared
//               instruction/data memory and the regex coprocessor cores.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_cmd_dispatcher_if #(
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 64,
    parameter int CHANNELS  = 4,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    // Host command channel
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [REG_WIDTH-1:0]          cmd;
    logic [CH_W-1:0]               cmd_channel;
    logic [REG_WIDTH-1:0]          cmd_addr;
    logic [REG_WIDTH-1:0]          cmd_data;

    // Response channel and per-channel status
    logic                          rsp_valid;
    logic                          rsp_error;
    logic [CNT_WIDTH-1:0]          rsp_data;
    logic [CHANNELS*REG_WIDTH-1:0] status;

    // Shared memory port
    logic                          mem_valid;
    logic                          mem_we;
    logic [REG_WIDTH-1:0]          mem_addr;
    logic [REG_WIDTH-1:0]          mem_wdata;
    logic                          mem_ack;
    logic [REG_WIDTH-1:0]          mem_rdata;

    // Coprocessor core control
    logic [CHANNELS-1:0]           core_start;
    logic [CHANNELS-1:0]           core_reset;
    logic [CHANNELS-1:0]           core_done;
    logic [CHANNELS-1:0]           core_accept;

    // Host / memory / core side of the bundle
    modport master (
        output cmd_valid, cmd, cmd_channel, cmd_addr, cmd_data,
        output mem_ack, mem_rdata, core_done, core_accept,
        input  cmd_ready, rsp_valid, rsp_error, rsp_data, status,
        input  mem_valid, mem_we, mem_addr, mem_wdata, core_start, core_reset
    );

    // Dispatcher side of the bundle
    modport slave (
        input  cmd_valid, cmd, cmd_channel, cmd_addr, cmd_data,
        input  mem_ack, mem_rdata, core_done, core_accept,
        output cmd_ready, rsp_valid, rsp_error, rsp_data, status,
        output mem_valid, mem_we, mem_addr, mem_wdata, core_start, core_reset
    );
endinterface
`default_nettype wire

// File: rtl/axi_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_dispatcher
// Description : Routes host opcodes to CHANNELS regex coprocessor cores or to
//               the shared memory, tracks a status code and a saturating
//               elapsed-clock counter per channel, and issues one response
//               per accepted command.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_cmd_dispatcher #(
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 64,
    parameter int CHANNELS  = 4,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    axi_cmd_dispatcher_if.slave bus
);

    // Opcodes
    localparam logic [REG_WIDTH-1:0] c_OP_NOP     = REG_WIDTH'(0);
    localparam logic [REG_WIDTH-1:0] c_OP_WRITE   = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] c_OP_READ    = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] c_OP_START   = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] c_OP_RESET   = REG_WIDTH'(4);
    localparam logic [REG_WIDTH-1:0] c_OP_RDCLK   = REG_WIDTH'(5);
    localparam logic [REG_WIDTH-1:0] c_OP_RESTART = REG_WIDTH'(6);

    // Channel status codes
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RUNNING  = 3'd1;
    localparam logic [2:0] c_ST_ACCEPTED = 3'd2;
    localparam logic [2:0] c_ST_REJECTED = 3'd3;
    localparam logic [2:0] c_ST_ERROR    = 3'd4;

    // Dispatcher FSM states
    localparam logic [1:0] c_FSM_IDLE = 2'd0;
    localparam logic [1:0] c_FSM_MEM  = 2'd1;
    localparam logic [1:0] c_FSM_RESP = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic [REG_WIDTH-1:0] r_addr;
    logic [REG_WIDTH-1:0] r_wdata;
    logic                 r_we;

    logic                 r_rsp_valid;
    logic                 r_rsp_error;
    logic [CNT_WIDTH-1:0] r_rsp_data;

    logic [2:0]           r_st  [CHANNELS];
    logic [CNT_WIDTH-1:0] r_cnt [CHANNELS];
    logic [CHANNELS-1:0]  r_core_start;
    logic [CHANNELS-1:0]  r_core_reset;

    logic                 w_cmd_ready;
    logic                 w_accept;
    logic                 w_bad_op;
    logic                 w_bad_ch;
    logic                 w_is_mem;
    logic                 w_go_mem;
    logic                 w_exec;
    logic [CH_W-1:0]      w_ch_idx;
    logic [2:0]           w_sel_st;
    logic [CNT_WIDTH-1:0] w_sel_cnt;

    logic                 w_set_st;
    logic [2:0]           w_new_st;
    logic                 w_do_start;
    logic                 w_do_reset;
    logic                 w_clr_cnt;
    logic [CNT_WIDTH-1:0] w_rsp_imm;

    assign w_cmd_ready = (r_state == c_FSM_IDLE);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_bad_op    = (bus.cmd > c_OP_RESTART);
    assign w_bad_ch    = (32'(bus.cmd_channel) >= 32'(CHANNELS));
    assign w_is_mem    = (bus.cmd == c_OP_WRITE) || (bus.cmd == c_OP_READ);
    // An out-of-range channel is rejected outright, even for memory opcodes
    assign w_go_mem    = w_accept && w_is_mem && !w_bad_ch;
    assign w_exec      = w_accept && !w_is_mem && !w_bad_ch;
    // Steer away from non-existent array entries when the channel is illegal
    assign w_ch_idx    = w_bad_ch ? '0 : bus.cmd_channel;
    assign w_sel_st    = r_st[w_ch_idx];
    assign w_sel_cnt   = r_cnt[w_ch_idx];

    // Decode the accepted opcode against the selected channel's current status
    always_comb begin
        w_set_st   = 1'b0;
        w_new_st   = w_sel_st;
        w_do_start = 1'b0;
        w_do_reset = 1'b0;
        w_clr_cnt  = 1'b0;
        w_rsp_imm  = '0;
        if (w_bad_op) begin
            w_set_st = 1'b1;
            w_new_st = c_ST_ERROR;
        end else begin
            case (bus.cmd)
                c_OP_START: begin
                    w_set_st = 1'b1;
                    if (w_sel_st == c_ST_RUNNING) begin
                        w_new_st = c_ST_ERROR;
                    end else begin
                        w_new_st   = c_ST_RUNNING;
                        w_do_start = 1'b1;
                        w_clr_cnt  = 1'b1;
                    end
                    w_rsp_imm = CNT_WIDTH'(w_new_st);
                end
                c_OP_RESTART: begin
                    w_set_st = 1'b1;
                    if ((w_sel_st == c_ST_ACCEPTED) || (w_sel_st == c_ST_REJECTED)) begin
                        w_new_st   = c_ST_RUNNING;
                        w_do_start = 1'b1;
                    end else begin
                        w_new_st = c_ST_ERROR;
                    end
                    w_rsp_imm = CNT_WIDTH'(w_new_st);
                end
                c_OP_RESET: begin
                    w_set_st   = 1'b1;
                    w_new_st   = c_ST_IDLE;
                    w_do_reset = 1'b1;
                    w_clr_cnt  = 1'b1;
                    w_rsp_imm  = CNT_WIDTH'(c_ST_IDLE);
                end
                c_OP_RDCLK: begin
                    w_rsp_imm = w_sel_cnt;
                end
                default: begin
                    w_rsp_imm = '0;
                end
            endcase
        end
    end

    // Dispatcher state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_FSM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dispatcher next-state: only memory opcodes leave IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FSM_IDLE: if (w_go_mem)    w_state_nxt = c_FSM_MEM;
            c_FSM_MEM:  if (bus.mem_ack) w_state_nxt = c_FSM_RESP;
            c_FSM_RESP:                  w_state_nxt = c_FSM_IDLE;
            default:                     w_state_nxt = c_FSM_IDLE;
        endcase
    end

    // Capture the memory request fields at acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_go_mem) begin
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_data;
            r_we    <= (bus.cmd == c_OP_WRITE);
        end
    end

    // One-cycle response: next cycle for immediate opcodes, after ack for memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
            if (w_accept && !w_go_mem) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= w_bad_op || w_bad_ch;
                r_rsp_data  <= (w_bad_op || w_bad_ch) ? '0 : w_rsp_imm;
            end else if ((r_state == c_FSM_MEM) && bus.mem_ack) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_we ? '0 : CNT_WIDTH'(bus.mem_rdata);
            end
        end
    end

    // Per-channel status and counter; a host command overrides a same-cycle core_done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_st[i]  <= c_ST_IDLE;
                r_cnt[i] <= '0;
            end
            r_core_start <= '0;
            r_core_reset <= '0;
        end else begin
            r_core_start <= '0;
            r_core_reset <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                // The done cycle itself still counts as a running cycle
                if (r_st[i] == c_ST_RUNNING) begin
                    if (r_cnt[i] != c_CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                    end
                    if (bus.core_done[i]) begin
                        r_st[i] <= bus.core_accept[i] ? c_ST_ACCEPTED : c_ST_REJECTED;
                    end
                end
                if (w_exec && (w_ch_idx == CH_W'(i))) begin
                    if (w_set_st) begin
                        r_st[i] <= w_new_st;
                    end
                    if (w_clr_cnt) begin
                        r_cnt[i] <= '0;
                    end
                    r_core_start[i] <= w_do_start;
                    r_core_reset[i] <= w_do_reset;
                end
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_error  = r_rsp_error;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.mem_valid  = (r_state == c_FSM_MEM);
    assign bus.mem_we     = (r_state == c_FSM_MEM) && r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.core_start = r_core_start;
    assign bus.core_reset = r_core_reset;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_status
        assign bus.status[g*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'(r_st[g]);
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_cmd_dispatcher
// Description : Directed self-checking bench for axi_cmd_dispatcher. A second
//               three-channel instance exercises an out-of-range channel index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_cmd_dispatcher;

    logic clk = 1'b0;
    logic reset;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   start1_cnt = 0;

    always #5 clk = ~clk;

    axi_cmd_dispatcher_if #(.REG_WIDTH(32), .CNT_WIDTH(64), .CHANNELS(4)) bus  ();
    axi_cmd_dispatcher_if #(.REG_WIDTH(32), .CNT_WIDTH(64), .CHANNELS(3)) bus3 ();

    axi_cmd_dispatcher #(.REG_WIDTH(32), .CNT_WIDTH(64), .CHANNELS(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    axi_cmd_dispatcher #(.REG_WIDTH(32), .CNT_WIDTH(64), .CHANNELS(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    // Count start pulses on channel 1
    always @(negedge clk) begin
        if (bus.core_start[1]) start1_cnt <= start1_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; returns in the cycle after acceptance
    task automatic send(input logic [31:0] op, input logic [1:0] ch);
        bus.cmd_valid   = 1'b1;
        bus.cmd         = op;
        bus.cmd_channel = ch;
        tick();
        bus.cmd_valid   = 1'b0;
        bus.cmd         = '0;
    endtask

    function automatic logic [31:0] st(input int ch);
        return bus.status[ch*32 +: 32];
    endfunction

    // Called in the first RUNNING cycle; core_done lands 'cycles' cycles after acceptance
    task automatic pulse_done(input int ch, input int cycles, input logic acc);
        repeat (cycles - 1) tick();
        bus.core_done[ch]   = 1'b1;
        bus.core_accept[ch] = acc;
        tick();
        bus.core_done   = '0;
        bus.core_accept = '0;
    endtask

    // Issue a memory op; the memory model acks on the 3rd mem_valid cycle
    task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, output logic [63:0] rsp, output int nvalid,
                          output int nbusy, output int rsp_k, output logic [31:0] seen_addr,
                          output logic seen_we, output logic [31:0] seen_wdata);
        bus.cmd_valid   = 1'b1;
        bus.cmd         = we ? 32'd1 : 32'd2;
        bus.cmd_channel = 2'd0;
        bus.cmd_addr    = addr;
        bus.cmd_data    = wdata;
        nvalid = 0; nbusy = 0; rsp_k = -1; rsp = '0;
        seen_addr = '0; seen_we = 1'b0; seen_wdata = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.cmd_valid = 1'b0;
            bus.mem_ack   = 1'b0;
            if (!bus.cmd_ready) nbusy++;
            if (bus.rsp_valid) begin
                rsp_k = k;
                rsp   = bus.rsp_data;
            end
            if (bus.mem_valid) begin
                if (nvalid == 0) begin
                    seen_addr  = bus.mem_addr;
                    seen_we    = bus.mem_we;
                    seen_wdata = bus.mem_wdata;
                end
                nvalid++;
                if (nvalid == 3) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        logic [63:0] rsp;
        int          nvalid, nbusy, rsp_k;
        logic [31:0] s_addr, s_wdata;
        logic        s_we;
        logic        saw_rsp;

        bus.cmd_valid = 1'b0; bus.cmd = '0; bus.cmd_channel = '0; bus.cmd_addr = '0;
        bus.cmd_data = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        bus.core_done = '0; bus.core_accept = '0;
        bus3.cmd_valid = 1'b0; bus3.cmd = '0; bus3.cmd_channel = '0; bus3.cmd_addr = '0;
        bus3.cmd_data = '0; bus3.mem_ack = 1'b0; bus3.mem_rdata = '0;
        bus3.core_done = '0; bus3.core_accept = '0;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_cmd_ready",  bus.cmd_ready, 1);
        check("rst_rsp_valid",  bus.rsp_valid, 0);
        check("rst_rsp_error",  bus.rsp_error, 0);
        check("rst_rsp_data",   bus.rsp_data, 0);
        check("rst_mem_valid",  bus.mem_valid, 0);
        check("rst_mem_addr",   bus.mem_addr, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_core_reset", bus.core_reset, 0);
        check("rst_status",     bus.status == '0, 1);

        // START ch0, accepted done 10 cycles after acceptance
        send(32'd3, 2'd0);
        check("start0_rsp_valid",  bus.rsp_valid, 1);
        check("start0_rsp_error",  bus.rsp_error, 0);
        check("start0_rsp_data",   bus.rsp_data, 1);
        check("start0_core_start", bus.core_start, 4'b0001);
        check("start0_status",     st(0), 1);
        pulse_done(0, 10, 1'b1);
        check("done0_status", st(0), 2);
        send(32'd5, 2'd0);
        check("clk0_rsp_data",  bus.rsp_data, 10);
        check("clk0_rsp_error", bus.rsp_error, 0);

        // WRITE then READ at 0x40: 3 mem cycles, response one cycle after ack,
        // busy for the 3 mem cycles plus the response cycle
        mem_op(1'b1, 32'h40, 32'hDEADBEEF, 32'h0, rsp, nvalid, nbusy, rsp_k, s_addr, s_we, s_wdata);
        check("wr_mem_cycles", nvalid, 3);
        check("wr_busy",       nbusy, 4);
        check("wr_rsp_cycle",  rsp_k, 3);
        check("wr_rsp_data",   rsp, 0);
        check("wr_mem_addr",   s_addr, 32'h40);
        check("wr_mem_we",     s_we, 1);
        check("wr_mem_wdata",  s_wdata, 32'hDEADBEEF);
        mem_op(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, rsp, nvalid, nbusy, rsp_k, s_addr, s_we, s_wdata);
        check("rd_mem_cycles", nvalid, 3);
        check("rd_busy",       nbusy, 4);
        check("rd_rsp_cycle",  rsp_k, 3);
        check("rd_rsp_data",   rsp, 64'hDEADBEEF);
        check("rd_mem_we",     s_we, 0);

        // START ch1 twice, then RESET ch1
        send(32'd3, 2'd1);
        check("start1_status",     st(1), 1);
        check("start1_core_start", bus.core_start, 4'b0010);
        send(32'd3, 2'd1);
        check("start1b_rsp_data",   bus.rsp_data, 4);
        check("start1b_core_start", bus.core_start, 0);
        check("start1b_status",     st(1), 4);
        tick();
        check("start1_pulse_count", start1_cnt, 1);
        send(32'd4, 2'd1);
        check("reset1_core_reset", bus.core_reset, 4'b0010);
        check("reset1_status",     st(1), 0);
        check("reset1_rsp_data",   bus.rsp_data, 0);

        // START ch2, reject after 5, RESTART, reject after 7 -> counter 12
        send(32'd3, 2'd2);
        pulse_done(2, 5, 1'b0);
        check("done2_status", st(2), 3);
        send(32'd5, 2'd2);
        check("clk2a_rsp_data", bus.rsp_data, 5);
        send(32'd6, 2'd2);
        check("restart2_core_start", bus.core_start, 4'b0100);
        check("restart2_rsp_data",   bus.rsp_data, 1);
        pulse_done(2, 7, 1'b0);
        check("done2b_status", st(2), 3);
        send(32'd5, 2'd2);
        check("clk2b_rsp_data", bus.rsp_data, 12);

        // RESTART from IDLE is an error
        send(32'd6, 2'd3);
        check("restart3_rsp_data",   bus.rsp_data, 4);
        check("restart3_core_start", bus.core_start, 0);

        // Illegal opcode on ch0
        send(32'd7, 2'd0);
        check("badop_rsp_valid",  bus.rsp_valid, 1);
        check("badop_rsp_error",  bus.rsp_error, 1);
        check("badop_rsp_data",   bus.rsp_data, 0);
        check("badop_status0",    st(0), 4);
        check("badop_status1",    st(1), 0);
        check("badop_status2",    st(2), 3);
        check("badop_core_start", bus.core_start, 0);
        send(32'd5, 2'd2);
        check("badop_clk2", bus.rsp_data, 12);

        // Out-of-range channel on the three-channel instance
        bus3.cmd_valid = 1'b1; bus3.cmd = 32'd3; bus3.cmd_channel = 2'd3;
        tick();
        bus3.cmd_valid = 1'b0;
        check("badch_rsp_valid",  bus3.rsp_valid, 1);
        check("badch_rsp_error",  bus3.rsp_error, 1);
        check("badch_rsp_data",   bus3.rsp_data, 0);
        check("badch_core_start", bus3.core_start, 0);
        check("badch_status",     bus3.status == '0, 1);
        bus3.cmd_valid = 1'b1; bus3.cmd = 32'd2; bus3.cmd_channel = 2'd3;
        tick();
        bus3.cmd_valid = 1'b0;
        check("badch_rd_error",     bus3.rsp_error, 1);
        check("badch_rd_mem_valid", bus3.mem_valid, 0);
        check("badch_rd_ready",     bus3.cmd_ready, 1);

        // RESET ch3 in the same cycle as core_done[3] while RUNNING
        send(32'd3, 2'd3);
        repeat (3) tick();
        bus.cmd_valid = 1'b1; bus.cmd = 32'd4; bus.cmd_channel = 2'd3;
        bus.core_done[3] = 1'b1; bus.core_accept[3] = 1'b1;
        tick();
        bus.cmd_valid = 1'b0; bus.cmd = '0;
        bus.core_done = '0; bus.core_accept = '0;
        check("race3_status",     st(3), 0);
        check("race3_core_reset", bus.core_reset, 4'b1000);
        send(32'd5, 2'd3);
        check("race3_clk", bus.rsp_data, 0);

        // Reset while a memory read is pending
        bus.cmd_valid = 1'b1; bus.cmd = 32'd2; bus.cmd_channel = 2'd0; bus.cmd_addr = 32'h80;
        tick();
        bus.cmd_valid = 1'b0; bus.cmd = '0;
        tick();
        check("pend_mem_valid", bus.mem_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_mem_valid", bus.mem_valid, 0);
        check("async_cmd_ready", bus.cmd_ready, 1);
        tick();
        reset = 1'b0;
        saw_rsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check("async_no_rsp",  saw_rsp, 0);
        check("async_status2", st(2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
